// File: rtl/basic_gemm_cim_tile.sv
// Compute-in-memory GeMM tile: signed int8 weight store plus 32-bit accumulators.
// Each cim strobe takes a 4-lane dot product of activations with one weight word.
module basic_gemm_cim_tile #(
  parameter int DEPTH   = 64,
  parameter int NUM_OUT = 16,
  parameter int ELEM_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        write,
  input  logic        cim,
  input  logic        partial_sum,
  input  logic        reset_output,
  input  logic [3:0]  output_reg,
  input  logic [31:0] address,
  input  logic [31:0] input_data,
  input  logic        debug,
  output logic [31:0] cim_output
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LANES = 32 / ELEM_W;

  logic [31:0] weight [DEPTH];
  logic [31:0] acc    [NUM_OUT];

  logic [AW-1:0] addr_idx;
  logic [31:0]   weight_word;
  logic          reg_valid;
  logic [31:0]   dot;

  // Upper address bits are ignored by design; debug has no hardware effect.
  logic unused_bits;
  assign unused_bits = ^{debug, address[31:AW]};

  assign addr_idx    = address[AW-1:0];
  assign weight_word = weight[addr_idx];
  assign reg_valid   = ({28'd0, output_reg} < NUM_OUT);

  // Signed lane products, sign-extended and summed in 32-bit two's complement.
  always_comb begin
    logic signed [ELEM_W-1:0]   a_lane;
    logic signed [ELEM_W-1:0]   w_lane;
    logic signed [2*ELEM_W-1:0] prod;
    // NOTE: combinational logic uses blocking '=' so the loop accumulates in order;
    // every variable gets a default first so no latch is inferred.
    dot    = '0;
    a_lane = '0;
    w_lane = '0;
    prod   = '0;
    for (int i = 0; i < LANES; i++) begin
      a_lane = input_data[ELEM_W*i +: ELEM_W];
      w_lane = weight_word[ELEM_W*i +: ELEM_W];
      prod   = a_lane * w_lane;
      dot    = dot + {{(32-2*ELEM_W){prod[2*ELEM_W-1]}}, prod};
    end
  end

  always_comb begin
    cim_output = '0;
    if (reg_valid) cim_output = acc[output_reg];
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the weight array must come out of reset cleared, so it is built from
      // flops with an explicit reset loop rather than an uninitialised RAM macro.
      for (int i = 0; i < DEPTH; i++)   weight[i] <= '0;
      for (int j = 0; j < NUM_OUT; j++) acc[j]    <= '0;
    end else if (cs) begin
      if (reset_output) begin
        for (int j = 0; j < NUM_OUT; j++) acc[j] <= '0;
      end else if (write) begin
        weight[addr_idx] <= input_data;
      end else if (cim && reg_valid) begin
        acc[output_reg] <= partial_sum ? acc[output_reg] + dot : dot;
      end
    end
  end

endmodule

// File: tb/tb_basic_gemm_cim_tile.sv
// Directed self-checking bench for basic_gemm_cim_tile with hand-computed results.
module tb_basic_gemm_cim_tile;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        write;
  logic        cim;
  logic        partial_sum;
  logic        reset_output;
  logic [3:0]  output_reg;
  logic [31:0] address;
  logic [31:0] input_data;
  logic        debug;
  logic [31:0] cim_output;

  int n_assert = 0;
  int n_fail   = 0;

  basic_gemm_cim_tile dut (
    .clk          (clk),
    .rst          (rst),
    .cs           (cs),
    .write        (write),
    .cim          (cim),
    .partial_sum  (partial_sum),
    .reset_output (reset_output),
    .output_reg   (output_reg),
    .address      (address),
    .input_data   (input_data),
    .debug        (debug),
    .cim_output   (cim_output)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; cs = 1'b1; write = 1'b0; cim = 1'b0;
    partial_sum = 1'b0; reset_output = 1'b0; debug = 1'b0;
  endtask

  // Apply the current strobes across one rising edge, then release them.
  task automatic cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    address = addr; input_data = data; write = 1'b1;
    cycle();
  endtask

  task automatic do_cim(input logic [31:0] addr, input logic [31:0] act,
                        input logic [3:0] r, input logic ps);
    address = addr; input_data = act; output_reg = r; partial_sum = ps; cim = 1'b1;
    cycle();
  endtask

  task automatic check(input string tag, input logic [3:0] r, input logic [31:0] expected);
    output_reg = r;
    #1;
    n_assert++;
    assert (cim_output === expected)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, cim_output, expected);
      end
  endtask

  initial begin
    idle();
    output_reg = 4'd0; address = '0; input_data = '0;

    rst = 1'b1;
    cycle();
    for (int r = 0; r < 16; r++) check($sformatf("reset_acc%0d", r), 4'(r), 32'h0);

    do_write(32'd3, 32'h0102_0304);
    do_cim(32'd3, 32'h0101_0101, 4'd2, 1'b0);
    check("dot_basic", 4'd2, 32'h0000_000A);
    check("other_reg_untouched", 4'd3, 32'h0);

    do_cim(32'd3, 32'hFF00_0000, 4'd2, 1'b1);
    check("accumulate_neg", 4'd2, 32'h0000_0009);

    // Write immediately followed by cim on the same word.
    do_write(32'd7, 32'h8080_8080);
    do_cim(32'd7, 32'h8080_8080, 4'd5, 1'b0);
    check("min_times_min", 4'd5, 32'h0001_0000);

    // Address 0x48 wraps to word 8.
    do_write(32'h0000_0048, 32'hFFFF_FFFF);
    do_cim(32'd8, 32'h0101_0101, 4'd6, 1'b0);
    check("neg_result_addr_wrap", 4'd6, 32'hFFFF_FFFC);
    do_cim(32'h0000_0108, 32'h0101_0101, 4'd6, 1'b1);
    check("accumulate_negative", 4'd6, 32'hFFFF_FFF8);

    debug = 1'b1;
    reset_output = 1'b1;
    cim = 1'b1; address = 32'd3; input_data = 32'h0101_0101; output_reg = 4'd2;
    cycle();
    check("rstout_acc2", 4'd2, 32'h0);
    check("rstout_acc5", 4'd5, 32'h0);
    check("rstout_acc6", 4'd6, 32'h0);

    write = 1'b1; cim = 1'b1;
    address = 32'd9; input_data = 32'h0202_0202; output_reg = 4'd4;
    cycle();
    check("write_beats_cim", 4'd4, 32'h0);
    do_cim(32'd9, 32'h0101_0101, 4'd4, 1'b0);
    check("write_stored", 4'd4, 32'h0000_0008);

    cs = 1'b0; write = 1'b1; address = 32'd9; input_data = 32'h7F7F_7F7F;
    cycle();
    cs = 1'b0; cim = 1'b1; address = 32'd3; input_data = 32'h0101_0101; output_reg = 4'd4;
    cycle();
    check("cs0_cim_hold", 4'd4, 32'h0000_0008);
    cs = 1'b0; reset_output = 1'b1;
    cycle();
    check("cs0_rstout_hold", 4'd4, 32'h0000_0008);
    do_cim(32'd9, 32'h0101_0101, 4'd7, 1'b0);
    check("cs0_weight_hold", 4'd7, 32'h0000_0008);

    do_cim(32'd3, 32'h0101_0101, 4'd2, 1'b0);
    check("pre_rst_acc", 4'd2, 32'h0000_000A);
    rst = 1'b1; cs = 1'b0;
    cycle();
    check("rst_clears_acc2", 4'd2, 32'h0);
    check("rst_clears_acc4", 4'd4, 32'h0);
    do_cim(32'd3, 32'h0101_0101, 4'd2, 1'b1);
    check("rst_clears_weight", 4'd2, 32'h0);
    do_write(32'd3, 32'h0102_0304);
    do_cim(32'd3, 32'h0101_0101, 4'd2, 1'b1);
    check("sum_restarts", 4'd2, 32'h0000_000A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
